mdu_seq_div: RTL and testbench

- Iterative radix-2 restoring divider for signed and unsigned 32-bit integer division; quotient truncates toward zero.
- Feeds the execute-stage multiply/divide unit: the MDU pulses Start, waits on Busy/Done, then latches Quotient into LO and Remainder into HI.
- Replaces single-cycle combinational division; fixed latency keeps MDU stall timing deterministic.

---
 rtl/mdu_seq_div_pkg.sv | 19 +
 rtl/mdu_seq_div.sv | 155 +++++++++++++++
 tb/tb_mdu_seq_div.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_seq_div_pkg.sv
// Shared MDU package: op-select codes, divider state encoding and width.
// Imported by the execute-stage multiply/divide logic.
package mdu_seq_div_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [2:0] MDU_OP_NONE  = 3'd0;
    localparam logic [2:0] MDU_OP_MULT  = 3'd1;
    localparam logic [2:0] MDU_OP_MULTU = 3'd2;
    localparam logic [2:0] MDU_OP_DIV   = 3'd3;
    localparam logic [2:0] MDU_OP_DIVU  = 3'd4;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

endpackage

// File: rtl/mdu_seq_div.sv
// Iterative radix-2 restoring divider, signed/unsigned, truncating quotient.
// Fixed latency: Start edge E, Done visible after edge E+WIDTH+2.
import mdu_seq_div_pkg::*;

module mdu_seq_div #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    input  logic             Cancel,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CW-1:0]    cnt;

    logic             op_signed;
    logic [WIDTH-1:0] op_dvd;
    logic [WIDTH-1:0] op_dvs;

    logic             neg_q;
    logic             neg_r;
    logic             dvs_zero;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] quo;
    logic [WIDTH:0]   rem;

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;

    logic             accept;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH+1:0] trial;
    logic             borrow;

    // A new request is taken only when idle or presenting a result.
    always_comb begin
        accept = Start & ~Cancel & ((state == S_IDLE) | (state == S_DONE));
    end

    // Sequencer next state; Cancel overrides everything, including Start.
    always_comb begin
        state_nxt = state;
        if (Cancel) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (Start) state_nxt = S_PREP;
                S_PREP: state_nxt = S_ITER;
                S_ITER: if (cnt == '0) state_nxt = S_FIX;
                S_FIX:  state_nxt = S_DONE;
                S_DONE: state_nxt = Start ? S_PREP : S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Operand signs and magnitudes for the unsigned core.
    always_comb begin
        dvd_neg = op_signed & op_dvd[WIDTH-1];
        dvs_neg = op_signed & op_dvs[WIDTH-1];
        dvd_abs = dvd_neg ? (~op_dvd + 1'b1) : op_dvd;
        dvs_abs = dvs_neg ? (~op_dvs + 1'b1) : op_dvs;
    end

    // One shift/trial-subtract step; the top bit of trial is the borrow.
    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        trial  = rem_sh - {2'b00, dvs_mag};
        borrow = trial[WIDTH+1];
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Capture the request operands when it is accepted.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            op_signed <= 1'b0;
            op_dvd    <= '0;
            op_dvs    <= '0;
        end else if (accept) begin
            op_signed <= Signed;
            op_dvd    <= Dividend;
            op_dvs    <= Divisor;
        end
    end

    // Magnitude setup in PREP, then one quotient bit per ITER cycle.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dvs_zero <= 1'b0;
            dvs_mag  <= '0;
            quo      <= '0;
            rem      <= '0;
            cnt      <= '0;
        end else if (state == S_PREP) begin
            neg_q    <= dvd_neg ^ dvs_neg;
            neg_r    <= dvd_neg;
            dvs_zero <= (op_dvs == '0);
            dvs_mag  <= dvs_abs;
            quo      <= dvd_abs;
            rem      <= '0;
            cnt      <= CW'(WIDTH - 1);
        end else if (state == S_ITER) begin
            rem <= borrow ? rem_sh[WIDTH:0] : trial[WIDTH:0];
            quo <= {quo[WIDTH-2:0], ~borrow};
            if (cnt != '0) cnt <= cnt - 1'b1;
        end
    end

    // Sign fix-up and result write; a zero divisor returns the raw dividend.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            q_reg <= '0;
            r_reg <= '0;
        end else if ((state == S_FIX) && !Cancel) begin
            if (dvs_zero) begin
                q_reg <= '1;
                r_reg <= op_dvd;
            end else begin
                q_reg <= neg_q ? (~quo + 1'b1) : quo;
                r_reg <= neg_r ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
            end
        end
    end

    // Status and result outputs.
    always_comb begin
        Busy      = (state == S_PREP) | (state == S_ITER) | (state == S_FIX);
        Done      = (state == S_DONE);
        Quotient  = q_reg;
        Remainder = r_reg;
    end

endmodule

// File: tb/tb_mdu_seq_div.sv
// Self-checking bench for mdu_seq_div: vector table, corner sequences,
// and randomized operations against an arithmetic reference model.
module tb_mdu_seq_div;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic          Clk;
    logic          Rst;
    logic          Start;
    logic          Signed;
    logic [W-1:0]  Dividend;
    logic [W-1:0]  Divisor;
    logic          Cancel;
    logic          Busy;
    logic          Done;
    logic [W-1:0]  Quotient;
    logic [W-1:0]  Remainder;

    int n_cmp;
    int n_bad;
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;

    mdu_seq_div #(.WIDTH(W)) dut (
        .Clk(Clk),
        .Rst(Rst),
        .Start(Start),
        .Signed(Signed),
        .Dividend(Dividend),
        .Divisor(Divisor),
        .Cancel(Cancel),
        .Busy(Busy),
        .Done(Done),
        .Quotient(Quotient),
        .Remainder(Remainder)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        bit          s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Reference: plain integer division, truncating toward zero.
    function automatic void ref_div(input bit s, input logic [31:0] a,
                                    input logic [31:0] b,
                                    output logic [31:0] q,
                                    output logic [31:0] r);
        int sa;
        int sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            sa = int'(a);
            sb = int'(b);
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
    endfunction

    task automatic issue(input bit s, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge Clk);
        Start    = 1'b1;
        Signed   = s;
        Dividend = a;
        Divisor  = b;
        @(posedge Clk);
        #1;
        Start = 1'b0;
    endtask

    task automatic wait_done(input int inj_k, input bit is,
                             input logic [31:0] ia, input logic [31:0] ib,
                             output int lat, output int bc);
        lat = -1;
        bc  = Busy ? 1 : 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge Clk);
            if (k == inj_k) begin
                Start    = 1'b1;
                Signed   = is;
                Dividend = ia;
                Divisor  = ib;
            end else begin
                Start = 1'b0;
            end
            @(posedge Clk);
            #1;
            if (Done) begin
                lat = k;
                break;
            end
            if (Busy) bc++;
        end
        Start = 1'b0;
    endtask

    task automatic run_op(input string name, input bit s,
                          input logic [31:0] a, input logic [31:0] b,
                          output int bc);
        int lat;
        issue(s, a, b);
        wait_done(-1, 1'b0, 32'd0, 32'd0, lat, bc);
        ref_div(s, a, b, exp_q, exp_r);
        check({name, " lat"}, 32'(lat), 32'(LAT));
        check({name, " q"}, Quotient, exp_q);
        check({name, " r"}, Remainder, exp_r);
    endtask

    initial begin
        int bc;
        int lat;
        int seen;
        bit rs;
        logic [31:0] ra;
        logic [31:0] rb;

        n_cmp    = 0;
        n_bad    = 0;
        Rst      = 1'b1;
        Start    = 1'b0;
        Signed   = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        Cancel   = 1'b0;

        tbl[0] = '{"u7/2",     1'b0, 32'd7,        32'd2,
                   32'd3,        32'd1};
        tbl[1] = '{"s-7/2",    1'b1, 32'hFFFFFFF9, 32'd2,
                   32'hFFFFFFFD, 32'hFFFFFFFF};
        tbl[2] = '{"s7/-2",    1'b1, 32'd7,        32'hFFFFFFFE,
                   32'hFFFFFFFD, 32'd1};
        tbl[3] = '{"umax/1",   1'b0, 32'hFFFFFFFF, 32'd1,
                   32'hFFFFFFFF, 32'd0};
        tbl[4] = '{"sovf",     1'b1, 32'h80000000, 32'hFFFFFFFF,
                   32'h80000000, 32'd0};
        tbl[5] = '{"udiv0",    1'b0, 32'h12345678, 32'd0,
                   32'hFFFFFFFF, 32'h12345678};
        tbl[6] = '{"sdiv0",    1'b1, 32'h12345678, 32'd0,
                   32'hFFFFFFFF, 32'h12345678};
        tbl[7] = '{"s-100/-7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,
                   32'd14,       32'hFFFFFFFE};

        repeat (3) @(posedge Clk);
        #1;
        check("rst busy", 32'(Busy), 32'd0);
        check("rst done", 32'(Done), 32'd0);
        check("rst q", Quotient, 32'd0);
        check("rst r", Remainder, 32'd0);
        @(negedge Clk);
        Rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            issue(tbl[i].s, tbl[i].a, tbl[i].b);
            wait_done(-1, 1'b0, 32'd0, 32'd0, lat, bc);
            check({tbl[i].name, " lat"}, 32'(lat), 32'(LAT));
            check({tbl[i].name, " busy"}, 32'(bc), 32'(W + 2));
            check({tbl[i].name, " q"}, Quotient, tbl[i].q);
            check({tbl[i].name, " r"}, Remainder, tbl[i].r);
            exp_q = tbl[i].q;
            exp_r = tbl[i].r;
        end

        // Cancel beats a simultaneous Start while idle.
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Start  = 1'b1;
        Cancel = 1'b1;
        @(posedge Clk);
        #1;
        Start  = 1'b0;
        Cancel = 1'b0;
        check("cancel+start busy", 32'(Busy), 32'd0);

        // Cancel mid-operation: no Done, outputs keep the last result.
        issue(1'b0, 32'd100, 32'd3);
        repeat (9) begin
            @(posedge Clk);
            #1;
        end
        @(negedge Clk);
        Cancel = 1'b1;
        @(posedge Clk);
        #1;
        Cancel = 1'b0;
        check("cancel busy", 32'(Busy), 32'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge Clk);
            #1;
            if (Done) seen++;
        end
        check("cancel no done", 32'(seen), 32'd0);
        check("cancel q hold", Quotient, exp_q);
        check("cancel r hold", Remainder, exp_r);
        run_op("after cancel 100/7", 1'b0, 32'd100, 32'd7, bc);
        check("100/7 q const", Quotient, 32'd14);
        check("100/7 r const", Remainder, 32'd2);

        // Start during ITER is ignored; original result arrives on time.
        issue(1'b0, 32'd1000, 32'd10);
        wait_done(5, 1'b0, 32'd50, 32'd5, lat, bc);
        check("midstart lat", 32'(lat), 32'(LAT));
        check("midstart q", Quotient, 32'd100);
        check("midstart r", Remainder, 32'd0);

        // Start in the DONE cycle is accepted back-to-back.
        issue(1'b1, 32'hFFFFFF9C, 32'd7);
        wait_done(-1, 1'b0, 32'd0, 32'd0, lat, bc);
        check("b2b lat", 32'(lat), 32'(LAT));
        check("b2b q", Quotient, 32'hFFFFFFF2);
        check("b2b r", Remainder, 32'hFFFFFFFE);

        // Reset mid-ITER clears everything; next op runs normally.
        issue(1'b0, 32'h0000DEAD, 32'd3);
        repeat (12) begin
            @(posedge Clk);
            #1;
        end
        @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        check("midrst busy", 32'(Busy), 32'd0);
        check("midrst done", 32'(Done), 32'd0);
        check("midrst q", Quotient, 32'd0);
        check("midrst r", Remainder, 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        run_op("after rst 100/7", 1'b0, 32'd100, 32'd7, bc);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = (($urandom_range(0, 3)) == 0) ? 32'($urandom_range(0, 300))
                                              : 32'($urandom);
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 8));
                default: rb = 32'($urandom);
            endcase
            run_op($sformatf("rand%0d", i), rs, ra, rb, bc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
